// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, one-cycle memory latency absorption, 2-entry queue, redirect.
// Define FETCH_PERF_EN to add the stall_cycles performance counter output.
module instruction_fetch #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              decode_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    fetch_entry_t      fifo_q [2];
    fetch_entry_t      fifo_d [2];
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;

    logic              pop;
    logic              issue;
    logic              tail;
    logic [2:0]        occ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= START_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            fifo_q    <= '{default: '0};
            head_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            fifo_q    <= fifo_d;
            head_q    <= head_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        pop   = instr_valid && decode_ready;
        // Words already owned (queued or in flight) after this cycle's pop.
        occ   = 3'(count_q) + 3'(pend_q) - 3'(pop);
        issue = (state_q == RUN) && (occ < 3'd2);
        tail  = head_q ^ count_q[0];

        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = 1'b0;
        pend_pc_d = pend_pc_q;
        fifo_d    = fifo_q;
        head_d    = head_q;
        count_d   = count_q;

        if (redirect_valid) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            pc_d    = redirect_target;
            state_d = (redirect_target <= LAST_PC) ? RUN : DONE;
        end else begin
            head_d  = head_q ^ pop;
            count_d = count_q - 2'(pop) + 2'(pend_q);
            if (pend_q) begin
                fifo_d[tail] = '{pc: pend_pc_q, instr: imem_data};
            end
            if (issue) begin
                pend_d    = 1'b1;
                pend_pc_d = pc_q;
                pc_d      = pc_q + 1'b1;
                if (pc_q == LAST_PC) begin
                    state_d = DONE;
                end
            end
        end
    end

    assign imem_address = pc_q;
    assign instr_valid  = (count_q != 2'd0);
    assign instruction  = instr_valid ? fifo_q[head_q].instr : '0;
    assign instr_pc     = instr_valid ? fifo_q[head_q].pc : '0;
    assign halted       = (state_q == DONE) && (count_q == 2'd0) && !pend_q;

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (instr_valid && !decode_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    // The issue rule keeps a full queue and an in-flight word mutually exclusive.
    assert property (@(posedge clock) disable iff (reset) !(count_q == 2'd2 && pend_q));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synchronous 16-word memory model (mem[i] = 16'h1000+i).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  imem_address;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [3:0]  instr_pc;
    logic        decode_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_target = 4'd0;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cycles;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] mem [16];

    instruction_fetch #(
        .ADDR_W(4), .DATA_W(16), .START_ADDR(0), .LAST_ADDR(8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .instr_valid     (instr_valid),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .decode_ready    (decode_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    end

    always @(posedge clock) imem_data <= mem[imem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_word(input string t, input int c, input int pc);
        check($sformatf("%s_c%0d_valid", t, c), 32'(instr_valid), 32'd1);
        check($sformatf("%s_c%0d_pc", t, c), 32'(instr_pc), 32'(pc));
        check($sformatf("%s_c%0d_instr", t, c), 32'(instruction), 32'h1000 + 32'(pc));
    endtask

    task automatic exp_none(input string t, input int c);
        check($sformatf("%s_c%0d_valid", t, c), 32'(instr_valid), 32'd0);
    endtask

    // Holds reset for two edges, checks reset values, releases #1 after an edge: that cycle is cycle 0.
    task automatic restart(input string t);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 4'd0;
        decode_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check({t, "_rst_valid"}, 32'(instr_valid), 32'd0);
        check({t, "_rst_instr"}, 32'(instruction), 32'd0);
        check({t, "_rst_pc"}, 32'(instr_pc), 32'd0);
        check({t, "_rst_halt"}, 32'(halted), 32'd0);
        check({t, "_rst_addr"}, 32'(imem_address), 32'd0);
`ifdef FETCH_PERF_EN
        check({t, "_rst_stall"}, 32'(stall_cycles), 32'd0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        // Straight run to the end of the program.
        restart("run");
        for (int c = 0; c <= 13; c++) begin
            if (c >= 2 && c <= 10) exp_word("run", c, c - 2);
            else exp_none("run", c);
            check($sformatf("run_c%0d_halt", c), 32'(halted), 32'(c >= 11));
            check($sformatf("run_c%0d_addr", c), 32'(imem_address), 32'(c <= 9 ? c : 9));
            step();
        end

        // Decode stalls in cycles 3..7.
        restart("stall");
        for (int c = 0; c <= 16; c++) begin
            if (c == 2) exp_word("stall", c, 0);
            else if (c >= 3 && c <= 7) exp_word("stall", c, 1);
            else if (c >= 8 && c <= 15) exp_word("stall", c, c - 7);
            else exp_none("stall", c);
            if (c >= 3 && c <= 7) check($sformatf("stall_c%0d_addr", c), 32'(imem_address), 32'd3);
            if (c == 16) check("stall_c16_halt", 32'(halted), 32'd1);
`ifdef FETCH_PERF_EN
            if (c == 3) check("stall_cnt_c3", 32'(stall_cycles), 32'd0);
            if (c == 8) check("stall_cnt_c8", 32'(stall_cycles), 32'd5);
`endif
            decode_ready = (c < 3 || c > 7);
            step();
        end

        // Redirect to 6 with pc 3 in flight, then redirect out of halt to 2, then to 8.
        restart("redir");
        for (int c = 0; c <= 24; c++) begin
            if (c >= 2 && c <= 4) exp_word("redir", c, c - 2);
            else if (c >= 7 && c <= 9) exp_word("redir", c, c - 1);
            else if (c >= 13 && c <= 19) exp_word("redir", c, c - 11);
            else if (c == 23) exp_word("redir", c, 8);
            else exp_none("redir", c);
            case (c)
                5:  check("redir_c5_addr", 32'(imem_address), 32'd6);
                9:  check("redir_c9_halt", 32'(halted), 32'd0);
                10: check("redir_c10_halt", 32'(halted), 32'd1);
                11: begin
                    check("redir_c11_halt", 32'(halted), 32'd0);
                    check("redir_c11_addr", 32'(imem_address), 32'd2);
                end
                20: check("redir_c20_halt", 32'(halted), 32'd1);
                21: check("redir_c21_addr", 32'(imem_address), 32'd8);
                22: check("redir_c22_halt", 32'(halted), 32'd0);
                24: begin
                    check("redir_c24_halt", 32'(halted), 32'd1);
                    check("redir_c24_addr", 32'(imem_address), 32'd9);
                end
                default: ;
            endcase
            redirect_valid = (c == 4 || c == 10 || c == 20);
            redirect_target = (c == 4) ? 4'd6 : (c == 10) ? 4'd2 : 4'd8;
            step();
        end
        redirect_valid = 1'b0;

        // Redirect beyond the last address while running.
        restart("far");
        for (int c = 0; c <= 7; c++) begin
            if (c >= 2 && c <= 3) exp_word("far", c, c - 2);
            else exp_none("far", c);
            check($sformatf("far_c%0d_halt", c), 32'(halted), 32'(c >= 4));
            if (c == 4) check("far_c4_addr", 32'(imem_address), 32'd12);
            redirect_valid = (c == 3);
            redirect_target = 4'd12;
            step();
        end
        redirect_valid = 1'b0;

        // Asynchronous reset with two words queued.
        restart("areset");
        for (int c = 0; c <= 3; c++) begin
            if (c >= 2) exp_word("areset", c, 0);
            decode_ready = (c < 2);
            if (c < 3) step();
        end
        #2;
        reset = 1'b1;
        #1;
        check("areset_async_valid", 32'(instr_valid), 32'd0);
        check("areset_async_addr", 32'(imem_address), 32'd0);
        check("areset_async_halt", 32'(halted), 32'd0);
        #2;
        reset = 1'b0;
        decode_ready = 1'b1;
        step();
        exp_none("areset_re", 1);
        step();
        exp_word("areset_re", 2, 0);
        step();
        exp_word("areset_re", 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
